// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave.
//   state_t    : FSM states (IDLE, SHIFT)
//   spi_mode_t : latched clock mode {cpol, cpha}
//   SPI_DATA_W : default frame width
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchroniser for an asynchronous pin, plus
// single-cycle rise/fall pulses derived from the synchronised level.
//   clk, rst_n : system clock, async active-low reset
//   din        : asynchronous input pin
//   sync       : synchronised level (2 flops)
//   rise, fall : one-cycle pulses on synchronised transitions
// RST_VAL sets the reset level of all three flops so an idle-high pin
// (SS_n) does not produce a false edge when reset releases.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
            prev_p2 <= RST_VAL;
        end else begin
            // p0 -> p1: metastability settling
            meta_p0 <= din;
            sync_p1 <= meta_p0;
            // p1 -> p2: edge history
            prev_p2 <= sync_p1;
        end
    end

    assign sync = sync_p1;
    assign rise = sync_p1 & ~prev_p2;
    assign fall = ~sync_p1 & prev_p2;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: clock-oversampled SPI slave, all CPOL/CPHA modes, MSB first.
//   clk, rst_n        : system clock, async active-low reset
//   SCLK, MOSI, SS_n  : SPI pins from the master (asynchronous)
//   MISO              : serial data to the master
//   CPOL, CPHA        : clock mode, latched at each SS_n fall
//   tx_data, tx_load  : write into the transmit holding register
//   tx_ready          : holding register empty
//   rx_data, rx_valid : last received byte and its one-cycle strobe
// Optional (macro SPI_SLAVE_OVERRUN_EN):
//   rx_ack            : host acknowledges the received byte
//   rx_overrun        : sticky, a byte completed while the previous was unacknowledged
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic              SS_n,
    output logic              MISO,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    input  logic              rx_ack,
    output logic              rx_overrun
`endif
);

    localparam int CNT_W = $clog2(DATA_W);

    logic sclk_sync_unused, sclk_rise, sclk_fall;
    logic ss_sync_unused, ss_rise, ss_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    state_t            state_q, state_d;
    spi_mode_t         mode_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] hold_q;
    logic              hold_full_q;
    logic [DATA_W-1:0] tx_src;
    logic              lead, trail;
    logic              start, sample_edge, drive_edge, byte_done, reload;

    // Pin synchronisers; SS_n idles high so its flops reset to 1
    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .din(SCLK),
        .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst_n(rst_n), .din(SS_n),
        .sync(ss_sync_unused), .rise(ss_rise), .fall(ss_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .din(MOSI),
        .sync(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    // Leading edge leaves the idle level, trailing edge returns to it
    assign lead  = mode_q.cpol ? sclk_fall : sclk_rise;
    assign trail = mode_q.cpol ? sclk_rise : sclk_fall;

    // Empty holding register at load time means underrun: send zeros
    assign tx_src   = hold_full_q ? hold_q : '0;
    assign tx_ready = ~hold_full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        sample_edge = 1'b0;
        drive_edge  = 1'b0;
        byte_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                // A deselect abandons any partial byte
                if (ss_rise) begin
                    state_d = IDLE;
                end else begin
                    sample_edge = mode_q.cpha ? trail : lead;
                    drive_edge  = mode_q.cpha ? lead : trail;
                    byte_done   = sample_edge && (cnt_q == CNT_W'(DATA_W - 1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign reload = start | byte_done;

    // Control and host-visible registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            MISO        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
        end else begin
            if (start) begin
                mode_q <= '{cpol: CPOL, cpha: CPHA};
                cnt_q  <= '0;
            end else if (byte_done) begin
                cnt_q  <= '0;
            end else if (sample_edge) begin
                cnt_q  <= cnt_q + CNT_W'(1);
            end

            // The reload empties the register a cycle before tx_ready is seen,
            // so a same-cycle tx_load is simply ignored (tx_ready still 0)
            if (reload && hold_full_q)
                hold_full_q <= 1'b0;
            else if (tx_load && !hold_full_q)
                hold_full_q <= 1'b1;

            if (start)
                MISO <= tx_src[DATA_W-1];
            else if (drive_edge)
                MISO <= shreg[DATA_W-1];

            rx_valid <= byte_done;
            if (byte_done)
                rx_data <= {shreg[DATA_W-2:0], mosi_s};
        end
    end

    // Data registers: meaningful only after a load, so no reset
    always_ff @(posedge clk) begin
        if (tx_load && !hold_full_q)
            hold_q <= tx_data;
        if (reload)
            shreg <= tx_src;
        else if (sample_edge)
            shreg <= {shreg[DATA_W-2:0], mosi_s};
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic pending_q;

    // Set beats clear when they coincide, for both flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_valid)    pending_q <= 1'b1;
            else if (rx_ack) pending_q <= 1'b0;

            if (byte_done && pending_q) rx_overrun <= 1'b1;
            else if (rx_ack)            rx_overrun <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave. The bench plays the SPI
// master (bit-banged SCLK/MOSI/SS_n, samples MISO) and compares against
// hand-computed bytes. Build with SPI_SLAVE_OVERRUN_EN to add overrun checks.
module tb_spi_slave;

    localparam int H = 8;  // SCLK half period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SCLK = 1'b0;
    logic       MOSI = 1'b0;
    logic       SS_n = 1'b1;
    logic       MISO;
    logic       CPOL = 1'b0;
    logic       CPHA = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       rx_ack = 1'b0;
    logic       rx_overrun;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int vld_cnt  = 0;
    logic [7:0] hist[$];

    spi_slave #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n), .MISO(MISO),
        .CPOL(CPOL), .CPHA(CPHA),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid)
`ifdef SPI_SLAVE_OVERRUN_EN
        , .rx_ack(rx_ack), .rx_overrun(rx_overrun)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            vld_cnt++;
            hist.push_back(rx_data);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        wait_clk(1);
    endtask

    task automatic frame_begin(input logic pol, input logic pha);
        CPOL = pol;
        CPHA = pha;
        SCLK = pol;
        MOSI = 1'b0;
        wait_clk(6);
        SS_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic frame_end();
        wait_clk(H);
        SS_n = 1'b1;
        wait_clk(8);
    endtask

    // Master side of one byte (or of the first nbits of it), MSB first
    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, input int nbits);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!CPHA) begin
                MOSI = tx[i];
                wait_clk(H);
                SCLK = ~CPOL;
                rx[i] = MISO;
                wait_clk(H);
                SCLK = CPOL;
            end else begin
                wait_clk(H);
                SCLK = ~CPOL;
                MOSI = tx[i];
                wait_clk(H);
                SCLK = CPOL;
                rx[i] = MISO;
            end
        end
    endtask

    initial begin
        logic [7:0] r0, r1;
        int base;

        // Reset state
        wait_clk(3);
        check_eq("rst_miso", MISO, 1'b0);
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_rx_valid", rx_valid, 1'b0);
        check_eq("rst_tx_ready", tx_ready, 1'b1);
`ifdef SPI_SLAVE_OVERRUN_EN
        check_eq("rst_overrun", rx_overrun, 1'b0);
`endif
        rst_n = 1'b1;
        wait_clk(4);

        // Mode 0: slave sends 3C (a second load while full is ignored)
        base = vld_cnt;
        load_tx(8'h3C);
        check_eq("m0_tx_ready_full", tx_ready, 1'b0);
        load_tx(8'h77);
        frame_begin(1'b0, 1'b0);
        xfer(8'hAA, r0, 8);
        frame_end();
        check_eq("m0_master_rx", r0, 8'h3C);
        check_eq("m0_rx_data", rx_data, 8'hAA);
        check_eq("m0_vld_pulses", vld_cnt - base, 1);
        check_eq("m0_tx_ready", tx_ready, 1'b1);

        // CPOL=1 CPHA=0
        load_tx(8'h5A);
        frame_begin(1'b1, 1'b0);
        xfer(8'hBB, r0, 8);
        frame_end();
        check_eq("m2_rx_data", rx_data, 8'hBB);
        check_eq("m2_master_rx", r0, 8'h5A);

        // CPHA=1, two bytes under one select; second byte loaded mid-frame
        base = vld_cnt;
        load_tx(8'hF0);
        frame_begin(1'b0, 1'b1);
        check_eq("m1_tx_ready_after_start", tx_ready, 1'b1);
        load_tx(8'h0F);
        xfer(8'h12, r0, 8);
        xfer(8'h34, r1, 8);
        frame_end();
        check_eq("m1_vld_pulses", vld_cnt - base, 2);
        check_eq("m1_byte0", (hist.size() > base) ? hist[base] : 8'hxx, 8'h12);
        check_eq("m1_byte1", (hist.size() > base + 1) ? hist[base + 1] : 8'hxx, 8'h34);
        check_eq("m1_master_rx0", r0, 8'hF0);
        check_eq("m1_master_rx1", r1, 8'h0F);

        // Underrun: nothing loaded
        frame_begin(1'b0, 1'b0);
        xfer(8'h81, r0, 8);
        frame_end();
        check_eq("ur_master_rx", r0, 8'h00);
        check_eq("ur_rx_data", rx_data, 8'h81);

        // Abort after 5 bits, then a full frame
        base = vld_cnt;
        frame_begin(1'b0, 1'b0);
        xfer(8'hFF, r0, 5);
        frame_end();
        check_eq("abort_no_vld", vld_cnt - base, 0);
        check_eq("abort_rx_data", rx_data, 8'h81);
        frame_begin(1'b0, 1'b0);
        xfer(8'hC3, r0, 8);
        frame_end();
        check_eq("after_abort_rx_data", rx_data, 8'hC3);
        check_eq("after_abort_vld", vld_cnt - base, 1);

        // Reset mid-frame
        load_tx(8'hFF);
        frame_begin(1'b0, 1'b0);
        load_tx(8'h55);
        xfer(8'h00, r0, 3);
        wait_clk(5);
        check_eq("pre_rst_miso", MISO, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_miso", MISO, 1'b0);
        check_eq("midrst_rx_data", rx_data, 8'h00);
        check_eq("midrst_rx_valid", rx_valid, 1'b0);
        check_eq("midrst_tx_ready", tx_ready, 1'b1);
        wait_clk(2);
        SS_n = 1'b1;
        SCLK = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);

`ifdef SPI_SLAVE_OVERRUN_EN
        // Two unacknowledged bytes raise overrun; ack clears it
        frame_begin(1'b0, 1'b0);
        xfer(8'h01, r0, 8);
        frame_end();
        check_eq("ovr_after_first", rx_overrun, 1'b0);
        frame_begin(1'b0, 1'b0);
        xfer(8'h02, r0, 8);
        frame_end();
        check_eq("ovr_after_second", rx_overrun, 1'b1);
        check_eq("ovr_rx_data", rx_data, 8'h02);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        wait_clk(1);
        check_eq("ovr_after_ack", rx_overrun, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

Clock-oversampled SPI slave: the peripheral end of the link driven by the team's SPI master (SCLK/MOSI in, MISO out). It synchronises the external SPI pins into the `clk` domain, shifts receive and transmit bytes in any CPOL/CPHA mode, and exposes a byte-level receive-valid and transmit-load handshake to the local host logic. Loopback benches pair it with the master: master MOSI drives slave MOSI, slave MISO drives master MISO.

## Interface
- `DATA_W`, 8: frame width in bits. Shift order is MSB first.
- `clk`  in  1  system clock; all logic is sampled on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `SCLK`  in  1  serial clock from the master; asynchronous to `clk`.
- `MOSI`  in  1  serial data from the master; asynchronous to `clk`.
- `SS_n`  in  1  active-low slave select; asynchronous to `clk`.
- `MISO`  out  1  serial data to the master.
- `CPOL`  in  1  idle level of SCLK; sampled at each SS_n fall.
- `CPHA`  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled at each SS_n fall.
- `tx_data`  in  DATA_W  next byte to transmit.
- `tx_load`  in  1  writes `tx_data` into the holding register; honoured only while `tx_ready`=1.
- `tx_ready`  out  1  holding register is empty.
- `rx_data`  out  DATA_W  last complete received byte; held until the next byte completes.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `rx_ack`, `rx_overrun`: these ports exist only when `SPI_SLAVE_OVERRUN_EN` is defined (see Configuration).

## Operation
- SCLK, MOSI and SS_n each pass through a 2-flop synchroniser. Edge detection runs on the synchronised SCLK and SS_n.
- Leading edge means SCLK leaves the CPOL level. Trailing edge means SCLK returns to it.
- FSM states:
  - IDLE: SS_n high. A falling SS_n latches CPOL/CPHA, loads the shift register and clears the bit counter, then goes to SHIFT.
  - SHIFT: on each sample edge, shift the synchronised MOSI into bit 0 and increment the 3-bit counter.
- Shift-register load source: the holding register if it is full (the holding register is then marked empty and `tx_ready` rises); otherwise `DATA_W'h00` (underrun).
- MISO output timing:
  - CPHA=0: MISO drives shift[MSB] from the SS_n fall and advances on each trailing edge.
  - CPHA=1: MISO advances on each leading edge. The first leading edge presents the MSB.
- Byte completion (8th sample edge): `rx_data` takes the shifted byte, `rx_valid` pulses, the counter wraps to 0, and the shift register reloads (same rule as above) for the next byte. The FSM stays in SHIFT while SS_n remains low.
- SS_n rises mid-byte: return to IDLE and discard the partial byte. No `rx_valid`; `rx_data` is unchanged. The holding register is not consumed by the aborted frame.
- `tx_load` while `tx_ready`=0 is ignored. A `tx_load` in the same cycle as a reload does not create a conflict: the reload empties the register one cycle before `tx_ready` is seen high.
- Reset at any time (including mid-frame) forces IDLE immediately.

## Timing
- Reset values: `MISO`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `rx_overrun`=0; synchronisers cleared, with SS_n synchroniser flops reset to 1.
- Input-to-action latency: 3 `clk` cycles from a pin change (2 synchroniser flops + 1 edge register).
- `rx_valid` asserts 1 cycle after the internal 8th sample edge, i.e. 4 cycles after the raw SCLK edge.
- SCLK high time and low time must each be ≥ 4 `clk` periods. SS_n setup before the first SCLK edge must be ≥ 4 `clk` periods.
- `tx_ready` rises the cycle after the holding register is consumed.

## Configuration
- `SPI_SLAVE_OVERRUN_EN` defined:
  - Adds input `rx_ack` and output `rx_overrun`.
  - A pending flag sets on `rx_valid` and clears on `rx_ack`. When set and clear coincide, set wins.
  - A byte completing while the flag is set still updates `rx_data`, and also sets sticky `rx_overrun`.
  - `rx_overrun` clears only on `rx_ack` or reset.
- Undefined: no pending tracking and no `rx_ack`/`rx_overrun` ports; `rx_data` is simply overwritten.

## Structure
- Package `spi_pkg`: FSM state enum (`IDLE`, `SHIFT`), `SPI_DATA_W` constant, and a mode typedef struct {cpol, cpha}.
- Sub-module `spi_sync_edge`: 2-flop synchroniser plus rise/fall pulse outputs. Instantiated for SCLK and SS_n; MOSI uses the synchroniser only.

## Test plan
- Mode 0, `tx_load` 8'h3C before frame, master sends 8'hAA → `rx_data`=8'hAA, one `rx_valid` pulse, master receives 8'h3C, `tx_ready` back to 1.
- CPOL=1 CPHA=0, master sends 8'hBB, slave holds 8'h5A → `rx_data`=8'hBB, master receives 8'h5A.
- CPHA=1, two back-to-back bytes 8'h12, 8'h34 under one SS_n low, slave loads 8'hF0 then 8'h0F → two `rx_valid` pulses with 8'h12 then 8'h34; master receives 8'hF0, 8'h0F.
- No `tx_load` (underrun), master sends 8'h81 → master receives 8'h00, `rx_data`=8'h81.
- SS_n raised after 5 SCLK periods, then a full 8'hC3 frame → no `rx_valid` for the abort, `rx_data`=8'hC3 after the second frame; reset asserted mid-frame → all outputs at reset values within 1 cycle.
- With `SPI_SLAVE_OVERRUN_EN`: two bytes with no `rx_ack` → `rx_overrun`=1 after the second byte; `rx_ack` → `rx_overrun`=0.
